// File: rtl/segment_scan_arbiter_if.sv
// ---------------------------------------------------------------------------
// segment_scan_arbiter_if
//   Bundles the display-arbiter signals between the two digit sources and the
//   4-digit common-anode seven-segment display.
//
//   a_segments   [3:0][7:0] source A cathode patterns, active-low, [0] = rightmost
//   b_segments   [3:0][7:0] source B cathode patterns, same encoding
//   b_req        request to show source B (pulse or level)
//   dim          [1:0] brightness select, present only with SEG_DIM_EN
//   b_active     source B currently selected
//   frame_start  one-cycle pulse on the first cycle of every frame
//   an           [3:0] anode enables, active-low
//   ca           [7:0] cathodes, active-low, bit 7 = decimal point
//
//   Modports: master drives sources/request and observes the display;
//             slave is the arbiter itself.
//   Optional feature macro: SEG_DIM_EN (adds the dim signal).
// ---------------------------------------------------------------------------
interface segment_scan_arbiter_if;
  logic [3:0][7:0] a_segments;
  logic [3:0][7:0] b_segments;
  logic            b_req;
  logic            b_active;
  logic            frame_start;
  logic [3:0]      an;
  logic [7:0]      ca;
`ifdef SEG_DIM_EN
  logic [1:0]      dim;

  modport master (
    output a_segments, b_segments, b_req, dim,
    input  b_active, frame_start, an, ca
  );

  modport slave (
    input  a_segments, b_segments, b_req, dim,
    output b_active, frame_start, an, ca
  );
`else
  modport master (
    output a_segments, b_segments, b_req,
    input  b_active, frame_start, an, ca
  );

  modport slave (
    input  a_segments, b_segments, b_req,
    output b_active, frame_start, an, ca
  );
`endif
endinterface

// File: rtl/segment_scan_arbiter.sv
// ---------------------------------------------------------------------------
// segment_scan_arbiter
//   Owns a 4-digit common-anode seven-segment display and shares it between
//   source A (measurement digits) and source B (status digits shown on request
//   for HOLD_FRAMES frames). Digits are time-multiplexed; every digit slot is
//   preceded by an all-off blanking interval to suppress ghosting. The source
//   and its four digit patterns are captured once per frame, so a frame never
//   shows a mix of old and new data.
//
//   Ports
//     clk      clock
//     resetn   asynchronous, active-low reset
//     bus      segment_scan_arbiter_if.slave:
//                a_segments, b_segments, b_req (and dim with SEG_DIM_EN) in;
//                b_active, frame_start, an, ca out (all registered)
//
//   Parameters
//     ON_CYCLES     cycles a digit is driven per slot (>=1)
//     BLANK_CYCLES  cycles all anodes are off before each digit (>=1)
//     HOLD_FRAMES   frames source B stays selected after its last request (>=1)
//
//   Optional feature macro: SEG_DIM_EN
//     Adds bus.dim, captured at each frame boundary. Within an ON phase the
//     digit is lit only for the first ON_CYCLES>>dim cycles; slot and frame
//     timing are unchanged.
// ---------------------------------------------------------------------------
module segment_scan_arbiter #(
  parameter int ON_CYCLES    = 10_000,
  parameter int BLANK_CYCLES = 100,
  parameter int HOLD_FRAMES  = 2_500
) (
  input  logic                  clk,
  input  logic                  resetn,
  segment_scan_arbiter_if.slave bus
);

  localparam int SLOT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W    = $clog2(SLOT_MAX + 1);
  localparam int HOLD_W   = $clog2(HOLD_FRAMES + 1);

  localparam logic [CNT_W-1:0]  ON_LAST     = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_FRAMES - 1);

  typedef enum logic {PH_BLANK, PH_ON} phase_e;
  typedef enum logic {SRC_A, SRC_B}    src_e;

  // Scan state
  phase_e           phase_q, phase_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             started_q;
  logic             boundary;

  // Source selection state
  src_e             sel_q,     sel_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic             pending_q, pending_d;
  logic [3:0][7:0]  snap_q,    snap_d;

  // Registered display outputs
  logic [3:0]       an_q, an_d;
  logic [7:0]       ca_q, ca_d;
  logic             fs_q;
  logic             drive;

`ifdef SEG_DIM_EN
  localparam int unsigned ON_U = ON_CYCLES;
  logic [1:0]       dim_q, dim_d;
`endif

  // ------------------------------------------------------------------------
  // Scan sequencer: digit 0..3, each BLANK then ON. The first edge after
  // reset release is treated as a frame boundary so the first frame captures
  // a fresh snapshot; the scan position itself stays at digit 0 BLANK count 0.
  // ------------------------------------------------------------------------
  always_comb begin
    phase_d  = phase_q;
    digit_d  = digit_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!started_q) begin
      boundary = 1'b1;
      phase_d  = PH_BLANK;
      digit_d  = 2'd0;
      cnt_d    = '0;
    end else if (phase_q == PH_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        phase_d = PH_ON;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == ON_LAST) begin
        phase_d  = PH_BLANK;
        cnt_d    = '0;
        digit_d  = digit_q + 2'd1;  // 3 wraps to 0
        boundary = (digit_q == 2'd3);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Source selection. Requests arriving mid-frame are remembered in pending;
  // a request sampled on the boundary edge itself is honoured right there.
  // Every honoured request reloads the hold counter, which gives retrigger.
  // The snapshot follows the newly selected source, not the old one.
  // ------------------------------------------------------------------------
  always_comb begin
    sel_d     = sel_q;
    hold_d    = hold_q;
    pending_d = pending_q | bus.b_req;
    snap_d    = snap_q;
`ifdef SEG_DIM_EN
    dim_d     = dim_q;
`endif
    if (boundary) begin
      pending_d = 1'b0;
      if (pending_q | bus.b_req) begin
        sel_d  = SRC_B;
        hold_d = HOLD_RELOAD;
      end else if (sel_q == SRC_B) begin
        if (hold_q == '0) begin
          sel_d = SRC_A;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      snap_d = (sel_d == SRC_B) ? bus.b_segments : bus.a_segments;
`ifdef SEG_DIM_EN
      dim_d  = bus.dim;
`endif
    end
  end

  // ------------------------------------------------------------------------
  // Output decode from the next scan position so an/ca are registered and
  // line up with the phase they belong to. The snapshot never changes on an
  // edge that enters an ON phase, so the current snapshot is the right one.
  // ------------------------------------------------------------------------
  always_comb begin
`ifdef SEG_DIM_EN
    // Lit only for the leading ON_CYCLES>>dim cycles of the ON phase.
    drive = (32'(cnt_d) < (ON_U >> dim_q));
`else
    drive = 1'b1;
`endif
    an_d = 4'hF;
    ca_d = 8'hFF;
    if (phase_d == PH_ON && drive) begin
      an_d = ~(4'b0001 << digit_d);
      ca_d = snap_q[digit_d];
    end
  end

  // ------------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q   <= PH_BLANK;
      digit_q   <= 2'd0;
      cnt_q     <= '0;
      started_q <= 1'b0;
      sel_q     <= SRC_A;
      hold_q    <= '0;
      pending_q <= 1'b0;
      snap_q    <= {4{8'hFF}};
      an_q      <= 4'hF;
      ca_q      <= 8'hFF;
      fs_q      <= 1'b0;
`ifdef SEG_DIM_EN
      dim_q     <= 2'd0;
`endif
    end else begin
      phase_q   <= phase_d;
      digit_q   <= digit_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      ca_q      <= ca_d;
      fs_q      <= boundary;
`ifdef SEG_DIM_EN
      dim_q     <= dim_d;
`endif
    end
  end

  assign bus.an          = an_q;
  assign bus.ca          = ca_q;
  assign bus.frame_start = fs_q;
  assign bus.b_active    = (sel_q == SRC_B);

endmodule
